// File: rtl/snake_head_pkg.sv
// Shared types for the snake head movement stage: direction and FSM state
// encodings plus the reversal helper.
package snake_pkg;

   // Direction encoding matches the upstream direction latch output.
   typedef enum logic [1:0] {
      UP    = 2'b00,
      RIGHT = 2'b01,
      DOWN  = 2'b10,
      LEFT  = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DEAD = 2'b10
   } head_state_t;

   // Opposite direction: flipping the MSB swaps UP<->DOWN and RIGHT<->LEFT.
   function automatic dir_t opposite(input dir_t d);
      logic [1:0] v;
      v = d ^ 2'b10;
      return dir_t'(v);
   endfunction

endpackage

// File: rtl/snake_head_if.sv
// Handshake bundle between the game controller, the direction stage and the
// snake head: control inputs (start, dir) and the published head status.
interface snake_head_if
   import snake_pkg::*;
#(
   parameter int GRID_W = 16,
   parameter int GRID_H = 16
);
   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);

   logic          start;
   dir_t          dir;
   logic [XW-1:0] head_x;
   logic [YW-1:0] head_y;
   logic          step;
   dir_t          cur_dir;
   logic          alive;
   logic          game_over;

   // Controller side: drives start/dir, observes head status.
   modport master (
      output start, dir,
      input  head_x, head_y, step, cur_dir, alive, game_over
   );

   // Snake head side.
   modport slave (
      input  start, dir,
      output head_x, head_y, step, cur_dir, alive, game_over
   );
endinterface

// File: rtl/snake_head_tick_gen.sv
// Game tick generator: counts clk cycles while enabled and pulses tick for
// one cycle every TICK_DIV cycles. The counter is held at zero when disabled
// so the first tick after enabling lands exactly TICK_DIV cycles later.
module tick_gen #(
   parameter int TICK_DIV = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count and tick pulse on the wrap cycle.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (that would infer a latch).
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         tick  = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/snake_head.sv
// Snake head movement stage. Advances the head one cell per game tick in the
// latched direction, rejects 180-degree reversals and handles grid edges.
// Build option SNAKE_HEAD_WRAP_EN: when defined the head wraps to the opposite
// edge instead of dying; when undefined leaving the grid moves the FSM to DEAD.
module snake_head
   import snake_pkg::*;
#(
   parameter int GRID_W   = 16,
   parameter int GRID_H   = 16,
   parameter int TICK_DIV = 8,
   parameter int START_X  = 8,
   parameter int START_Y  = 8
) (
   input  logic         clk,
   input  logic         reset,
   snake_head_if.slave  bus
);
   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);

   localparam logic [XW-1:0]        X_START = XW'(START_X);
   localparam logic [YW-1:0]        Y_START = YW'(START_Y);
   localparam logic signed [XW:0]   X_MAX   = (XW+1)'(GRID_W - 1);
   localparam logic signed [YW:0]   Y_MAX   = (YW+1)'(GRID_H - 1);

   head_state_t   state_q, state_d;
   logic [XW-1:0] head_x_q, head_x_d;
   logic [YW-1:0] head_y_q, head_y_d;
   dir_t          cur_dir_q, cur_dir_d;
   logic          step_q, step_d;
   logic          alive_q, alive_d;
   logic          game_over_q, game_over_d;

   logic          run_en;
   logic          tick;

   dir_t              nd;
   logic signed [XW:0] dx, nx;
   logic signed [YW:0] dy, ny;
   logic              off_grid;
   logic [XW-1:0]     tgt_x;
   logic [YW-1:0]     tgt_y;
   logic              move_ok;

   assign run_en = (state_q == RUN);

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .en    (run_en),
      .tick  (tick)
   );

   // Candidate next cell for the direction that would be applied on this tick.
   always_comb begin
      nd = (bus.dir == opposite(cur_dir_q)) ? cur_dir_q : bus.dir;
      dx = '0;
      dy = '0;
      case (nd)
         UP:    dy = '1;
         DOWN:  dy = (YW+1)'(1);
         LEFT:  dx = '1;
         RIGHT: dx = (XW+1)'(1);
         default: ;
      endcase
      nx = $signed({1'b0, head_x_q}) + dx;
      ny = $signed({1'b0, head_y_q}) + dy;
      // With a power-of-two grid, stepping past the last cell overflows the
      // sign bit and reads as negative, so the single check still flags it.
      off_grid = (nx < 0) || (nx > X_MAX) || (ny < 0) || (ny > Y_MAX);
`ifdef SNAKE_HEAD_WRAP_EN
      tgt_x = nx[XW-1:0];
      tgt_y = ny[YW-1:0];
      if (off_grid) begin
         if (nd == RIGHT) tgt_x = '0;
         if (nd == LEFT)  tgt_x = XW'(GRID_W - 1);
         if (nd == DOWN)  tgt_y = '0;
         if (nd == UP)    tgt_y = YW'(GRID_H - 1);
      end
      move_ok = 1'b1;
`else
      tgt_x   = nx[XW-1:0];
      tgt_y   = ny[YW-1:0];
      move_ok = !off_grid;
`endif
   end

   // FSM next-state and registered-output computation.
   always_comb begin
      state_d   = state_q;
      head_x_d  = head_x_q;
      head_y_d  = head_y_q;
      cur_dir_d = cur_dir_q;
      step_d    = 1'b0;
      case (state_q)
         IDLE, DEAD: begin
            if (bus.start) begin
               state_d   = RUN;
               head_x_d  = X_START;
               head_y_d  = Y_START;
               cur_dir_d = RIGHT;
            end
         end
         RUN: begin
            if (tick) begin
               cur_dir_d = nd;
               if (move_ok) begin
                  head_x_d = tgt_x;
                  head_y_d = tgt_y;
                  step_d   = 1'b1;
               end else begin
                  state_d = DEAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      alive_d     = (state_d == RUN);
      game_over_d = (state_d == DEAD);
   end

   // State and output registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         head_x_q    <= X_START;
         head_y_q    <= Y_START;
         cur_dir_q   <= RIGHT;
         step_q      <= 1'b0;
         alive_q     <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_x_q    <= head_x_d;
         head_y_q    <= head_y_d;
         cur_dir_q   <= cur_dir_d;
         step_q      <= step_d;
         alive_q     <= alive_d;
         game_over_q <= game_over_d;
      end
   end

   assign bus.head_x    = head_x_q;
   assign bus.head_y    = head_y_q;
   assign bus.cur_dir   = cur_dir_q;
   assign bus.step      = step_q;
   assign bus.alive     = alive_q;
   assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_snake_head.sv
// Self-checking bench for snake_head: directed scenarios followed by random
// direction/start traffic, all compared against a cell-level game model.
module tb_snake_head;
   import snake_pkg::*;

   localparam int GW  = 16;
   localparam int GH  = 16;
   localparam int DIV = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   snake_head_if #(.GRID_W(GW), .GRID_H(GH)) bus ();

   snake_head #(
      .GRID_W   (GW),
      .GRID_H   (GH),
      .TICK_DIV (DIV),
      .START_X  (8),
      .START_Y  (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Game model: 0=idle 1=run 2=dead; directions 0=up 1=right 2=down 3=left.
   int m_state, m_x, m_y, m_dir, m_since;
   bit m_step;

   function void model_reset();
      m_state = 0; m_x = 8; m_y = 8; m_dir = 1; m_since = 0; m_step = 0;
   endfunction

   function void model_edge(input bit start, input int d);
      int nd, nx, ny;
      m_step = 0;
      if (m_state == 1) begin
         m_since++;
         if (m_since % DIV == 0) begin
            nd = (d == (m_dir + 2) % 4) ? m_dir : d;
            m_dir = nd;
            nx = m_x + ((nd == 1) ? 1 : 0) - ((nd == 3) ? 1 : 0);
            ny = m_y + ((nd == 2) ? 1 : 0) - ((nd == 0) ? 1 : 0);
            if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) begin
               m_x = nx; m_y = ny; m_step = 1;
            end else begin
`ifdef SNAKE_HEAD_WRAP_EN
               m_x = (nx + GW) % GW; m_y = (ny + GH) % GH; m_step = 1;
`else
               m_state = 2;
`endif
            end
         end
      end else if (start) begin
         m_state = 1; m_x = 8; m_y = 8; m_dir = 1; m_since = 0;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("head_x",    32'(bus.head_x),    m_x);
      chk("head_y",    32'(bus.head_y),    m_y);
      chk("cur_dir",   32'(bus.cur_dir),   m_dir);
      chk("step",      32'(bus.step),      32'(m_step));
      chk("alive",     32'(bus.alive),     (m_state == 1) ? 1 : 0);
      chk("game_over", 32'(bus.game_over), (m_state == 2) ? 1 : 0);
   endtask

   // One clock edge: advance the model with the inputs held across the edge,
   // then compare just after the edge.
   task automatic cyc();
      @(posedge clk);
      if (!reset) model_reset();
      else        model_edge(bus.start, int'(bus.dir));
      #1;
      compare_all();
   endtask

   // Advance until the DUT pulses step, bounded by two tick periods.
   task automatic wait_step(input string tag, output int n);
      bit seen = 0;
      n = 0;
      for (int i = 0; i < 2 * DIV; i++) begin
         cyc();
         n++;
         if (bus.step === 1'b1) begin
            seen = 1;
            break;
         end
      end
      if (!seen) chk({tag, "_step_seen"}, 32'(bus.step), 1);
   endtask

   initial begin
      int n;
      int steps_seen;
      bus.start = 1'b0;
      bus.dir   = RIGHT;
      model_reset();

      // Reset state.
      repeat (2) cyc();
      chk("rst_head_x", 32'(bus.head_x), 8);
      chk("rst_head_y", 32'(bus.head_y), 8);
      chk("rst_alive",  32'(bus.alive), 0);
      reset = 1'b1;
      repeat (3) cyc();

      // T2: start, then RIGHT held; first move exactly DIV cycles after entry.
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk("t2_alive", 32'(bus.alive), 1);
      wait_step("t2a", n);
      chk("t2_latency", n, DIV);
      chk("t2_x9", 32'(bus.head_x), 9);
      chk("t2_y8", 32'(bus.head_y), 8);
      wait_step("t2b", n);
      chk("t2_period", n, DIV);
      chk("t2_x10", 32'(bus.head_x), 10);

      // T3: reversal rejected, then turn UP.
      bus.dir = LEFT;
      wait_step("t3a", n);
      chk("t3_x11", 32'(bus.head_x), 11);
      chk("t3_dir_right", 32'(bus.cur_dir), 1);
      bus.dir = UP;
      wait_step("t3b", n);
      chk("t3_y7", 32'(bus.head_y), 7);
      chk("t3_dir_up", 32'(bus.cur_dir), 0);

      // T6: dir toggles between ticks; only the value on the tick cycle counts.
      for (int k = 0; k < DIV - 1; k++) begin
         bus.dir = (k % 2 == 0) ? UP : DOWN;
         cyc();
      end
      bus.dir = LEFT;
      cyc();
      chk("t6_step", 32'(bus.step), 1);
      chk("t6_x10", 32'(bus.head_x), 10);
      chk("t6_y7", 32'(bus.head_y), 7);
      chk("t6_dir_left", 32'(bus.cur_dir), 3);

      // T4: run off the right edge.
      bus.dir = DOWN;
      wait_step("t4a", n);
      bus.dir = RIGHT;
      for (int i = 0; i < 8 && bus.head_x != 4'd15; i++) wait_step("t4b", n);
      chk("t4_at_x15", 32'(bus.head_x), 15);
      steps_seen = 0;
      for (int i = 0; i < DIV; i++) begin
         cyc();
         if (bus.step === 1'b1) steps_seen++;
      end
`ifdef SNAKE_HEAD_WRAP_EN
      chk("t4_wrap_x0", 32'(bus.head_x), 0);
      chk("t4_wrap_steps", steps_seen, 1);
      chk("t4_wrap_alive", 32'(bus.alive), 1);
`else
      chk("t4_game_over", 32'(bus.game_over), 1);
      chk("t4_alive", 32'(bus.alive), 0);
      chk("t4_x15", 32'(bus.head_x), 15);
      chk("t4_no_step", steps_seen, 0);
      repeat (2 * DIV) cyc();
      chk("t4_frozen_x", 32'(bus.head_x), 15);
`endif
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk("t4_restart_x", 32'(bus.head_x), 8);
      chk("t4_restart_y", 32'(bus.head_y), 8);
      chk("t4_restart_alive", 32'(bus.alive), 1);
      chk("t4_restart_dir", 32'(bus.cur_dir), 1);

      // T5: run off the top edge.
      bus.dir = UP;
      for (int i = 0; i < 10 && bus.head_y != 4'd0; i++) wait_step("t5a", n);
      chk("t5_at_y0", 32'(bus.head_y), 0);
      repeat (DIV) cyc();
`ifdef SNAKE_HEAD_WRAP_EN
      chk("t5_wrap_y15", 32'(bus.head_y), 15);
      chk("t5_wrap_step", 32'(bus.step), 1);
      chk("t5_wrap_alive", 32'(bus.alive), 1);
`else
      chk("t5_game_over", 32'(bus.game_over), 1);
      chk("t5_y0", 32'(bus.head_y), 0);
      chk("t5_no_step", 32'(bus.step), 0);
`endif
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      repeat (3) cyc();

      // T1: asynchronous reset mid-RUN, observed before any clock edge.
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("t1_head_x", 32'(bus.head_x), 8);
      chk("t1_head_y", 32'(bus.head_y), 8);
      chk("t1_dir", 32'(bus.cur_dir), 1);
      chk("t1_alive", 32'(bus.alive), 0);
      chk("t1_step", 32'(bus.step), 0);
      compare_all();
      cyc();
      reset = 1'b1;
      repeat (2) cyc();

      // Random traffic: random direction every cycle, occasional start.
      for (int i = 0; i < 600; i++) begin
         bus.dir   = dir_t'(2'($urandom_range(0, 3)));
         bus.start = ($urandom_range(0, 15) == 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
